alu_share_arbiter: RTL

Shares the single combinational `alu` datapath between two requesters, e.g. the pipeline execute stage and a debug/self-test unit. It accepts operations over a valid/ready handshake and selects requesters round-robin or by fixed priority. It drives the ALU from registered operands and returns the registered `ALUOut` and `Branch_Enable` to the requester that issued the operation. It sits between the requesters and the `alu` instance; the `ALUControl` decoding stays on the requester side.

---
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters over valid/ready.
// The arbiter registers the operands into the ALU and registers the result back to the owner.
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int CTL_W      = 7,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [CTL_W-1:0] req0_ctl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [CTL_W-1:0] req1_ctl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_branch,

    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_branch,

    output logic [CTL_W-1:0] alu_ctl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_branch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_rr_last;
    logic [CTL_W-1:0] r_ctl;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_branch;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept0;
    logic             w_accept1;
    logic             w_owner_ready;

    // Under contention, round-robin favours whoever was not served last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO || r_rr_last) begin
                w_grant0 = 1'b1;
            end else begin
                w_grant1 = 1'b1;
            end
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    // rst_n gating keeps both readys low for the whole time reset is held.
    assign w_accept0     = rst_n && (r_state == IDLE) && w_grant0;
    assign w_accept1     = rst_n && (r_state == IDLE) && w_grant1;
    assign w_owner_ready = r_owner ? resp1_ready : resp0_ready;

    assign req0_ready    = w_accept0;
    assign req1_ready    = w_accept1;

    assign resp0_valid   = (r_state == RESP) && !r_owner;
    assign resp1_valid   = (r_state == RESP) &&  r_owner;
    assign resp0_result  = r_result;
    assign resp1_result  = r_result;
    assign resp0_branch  = r_branch;
    assign resp1_branch  = r_branch;

    assign alu_ctl       = r_ctl;
    assign alu_a         = r_a;
    assign alu_b         = r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_rr_last <= 1'b1;
            r_ctl     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_branch  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept0) begin
                        r_ctl     <= req0_ctl;
                        r_a       <= req0_a;
                        r_b       <= req0_b;
                        r_owner   <= 1'b0;
                        r_rr_last <= 1'b0;
                        r_state   <= EXEC;
                    end else if (w_accept1) begin
                        r_ctl     <= req1_ctl;
                        r_a       <= req1_a;
                        r_b       <= req1_b;
                        r_owner   <= 1'b1;
                        r_rr_last <= 1'b1;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= alu_out;
                    r_branch <= alu_branch;
                    r_state  <= RESP;
                end
                RESP: begin
                    if (w_owner_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
